// File: rtl/cs_pkg.sv
// Shared types and constants for the CS stream controller.
package cs_pkg;

   localparam int DW  = 8;               // sample width (X)
   localparam int YW  = 10;              // CS result width (Y)
   localparam int WIN = 9;               // CS window length
   localparam int HW  = WIN - 1;         // history ring depth
   localparam int HCW = $clog2(WIN);     // holds history counts 0..HW
   localparam int HIW = $clog2(HW);      // indexes the history ring

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      STALL,
      REPLAY,
      DRAIN
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

endpackage

// File: rtl/cs_out_fifo.sv
// Synchronous result FIFO; the count output feeds the input credit check.
module cs_out_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // storage write; contents need no reset since count gates the head
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // pointer and occupancy tracking; push and pop together leave count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cs_stream_ctrl.sv
// Sequencer feeding the stall-less CS window datapath from a valid/ready
// stream; rebuilds the CS window by replaying history after any gap.
module cs_stream_ctrl
   import cs_pkg::*;
#(
   parameter int CS_LAT      = 1,
   parameter int OFIFO_DEPTH = 4,
   parameter int LENW        = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [LENW-1:0] cfg_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic [DW-1:0]   cs_x,
   input  logic [YW-1:0]   cs_y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [YW-1:0]   out_data,
   output logic            out_last,
   output logic            busy,
   output logic            done,
   output logic            cfg_err
);

   localparam int CW = $clog2(OFIFO_DEPTH) + 1;

   state_t          state;
   state_t          ret_state;
   logic [LENW-1:0] remain;
   logic [HCW-1:0]  hist_cnt;
   logic [HIW-1:0]  rep_idx;
   logic [DW-1:0]   hist [HW];
   tag_t            tag_p [CS_LAT];
   logic [CW-1:0]   fifo_cnt;
   logic [CW-1:0]   inflight;
   logic            credit;
   logic            accept;
   logic            push;
   logic            pop;

   // count result tags still travelling toward the FIFO
   always_comb begin
      inflight = '0;
      for (int i = 0; i < CS_LAT; i++) begin
         inflight = inflight + CW'(tag_p[i].valid);
      end
   end

   // a new sample is only taken if its eventual result is sure to find room
   assign credit   = (CW'(OFIFO_DEPTH) - fifo_cnt) > inflight;
   assign in_ready = ((state == FILL) || (state == RUN)) && credit;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);
   assign push     = tag_p[CS_LAT-1].valid;
   assign pop      = out_valid && out_ready;
   assign out_valid = (fifo_cnt != '0);

   // history ring: newest sample at the top, oldest at index 0
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < HW - 1; i++) begin
            hist[i] <= hist[i+1];
         end
         hist[HW-1] <= in_data;
      end
   end

   // tag pipe aligned with CS latency: marks which cs_y values are real results
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CS_LAT; i++) begin
            tag_p[i] <= '0;
         end
      end else begin
         tag_p[0] <= '{valid: accept && (state == RUN),
                       last:  (remain == LENW'(1))};
         for (int i = 1; i < CS_LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   // frame sequencer with registered cs_x, done and cfg_err
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ret_state <= FILL;
         remain    <= '0;
         hist_cnt  <= '0;
         rep_idx   <= '0;
         cs_x      <= '0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (accept) begin
            cs_x   <= in_data;
            remain <= remain - 1'b1;
            if (hist_cnt != HCW'(HW)) begin
               hist_cnt <= hist_cnt + 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_len >= LENW'(WIN)) begin
                     state    <= FILL;
                     remain   <= cfg_len;
                     hist_cnt <= '0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (accept) begin
                  if (hist_cnt == HCW'(HW - 1)) begin
                     state <= RUN;
                  end
               end else begin
                  state     <= STALL;
                  ret_state <= FILL;
               end
            end
            RUN: begin
               if (accept) begin
                  if (remain == LENW'(1)) begin
                     state <= DRAIN;
                  end
               end else begin
                  state     <= STALL;
                  ret_state <= RUN;
               end
            end
            STALL: begin
               // CS kept shifting the held cs_x, so its window is stale here
               if (in_valid && credit) begin
                  if (hist_cnt != '0) begin
                     state   <= REPLAY;
                     rep_idx <= HIW'(HCW'(HW) - hist_cnt);
                  end else begin
                     state <= FILL;
                  end
               end
            end
            REPLAY: begin
               cs_x <= hist[rep_idx];
               if (rep_idx == HIW'(HW - 1)) begin
                  state <= ret_state;
               end else begin
                  rep_idx <= rep_idx + 1'b1;
               end
            end
            DRAIN: begin
               if ((inflight == '0) && (fifo_cnt == '0)) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   cs_out_fifo #(
      .W     (YW + 1),
      .DEPTH (OFIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({tag_p[CS_LAT-1].last, cs_y}),
      .pop       (pop),
      .pop_data  ({out_last, out_data}),
      .count     (fifo_cnt)
   );

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Directed bench for cs_stream_ctrl with a weighted-window CS model in loop
// and a scoreboard of expected results.
module tb_cs_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] cfg_len;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [7:0]  cs_x;
   logic [9:0]  cs_y;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        cfg_err;

   typedef struct {
      logic       last;
      logic [9:0] y;
   } exp_t;

   exp_t exp_q[$];
   int   s [20];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nres = 0;
   int   first_valid = -1;
   int   last_pop = -1;
   logic [7:0] sr [8];

   always #5 clk = ~clk;

   cs_stream_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cs_x      (cs_x),
      .cs_y      (cs_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   // CS model: window register shifts every edge, Y combinational over window
   always @(posedge clk) begin
      for (int i = 0; i < 7; i++) sr[i] <= sr[i+1];
      sr[7] <= cs_x;
   end

   always_comb begin
      int acc;
      acc = 9 * int'(cs_x);
      for (int i = 0; i < 8; i++) acc = acc + (i + 1) * int'(sr[i]);
      cs_y = 10'(acc);
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] gold(input int j);
      int acc = 0;
      for (int i = 0; i < 9; i++) acc = acc + (i + 1) * s[j-8+i];
      return 10'(acc);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // output monitor: pops the scoreboard on every handshake
   always @(negedge clk) begin
      if (!reset && out_valid && first_valid < 0) first_valid = cyc;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", out_data, e.y);
            check("out_last", out_last, e.last);
         end
         nres++;
         last_pop = cyc;
      end
   end

   task automatic run_frame(input int len, input int gap_at, input int gap_len,
                            input int bp_at, input int bp_len, input int abort_at,
                            output int waits, output int a8);
      int idx = 0;
      int gap_left = 0;
      int cn = 0;
      waits = 0;
      a8 = -1;
      @(posedge clk); #1;
      start = 1'b1; cfg_len = 16'(len); in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      nres = 0; first_valid = -1; last_pop = -1;
      while (idx < len && cn < 1000 && !(abort_at >= 0 && idx >= abort_at)) begin
         if (gap_left > 0) begin
            in_valid = 1'b0;
            gap_left--;
         end else begin
            in_valid = 1'b1;
            in_data  = 8'(s[idx]);
         end
         out_ready = !(cn >= bp_at && cn < bp_at + bp_len);
         start     = (cn == 3);
         cfg_len   = (cn == 3) ? 16'd8 : 16'(len);
         @(negedge clk);
         if (cn == 4) begin
            check("busy_in_frame", busy, 1);
            check("start_busy_ignored", cfg_err, 0);
         end
         if (cn == bp_at + bp_len - 1) check("bp_in_ready_low", in_ready, 0);
         if (in_valid && in_ready) begin
            if (idx >= 8) exp_q.push_back('{last: (idx == len - 1), y: gold(idx)});
            if (idx == 8) a8 = cyc;
            idx++;
            if (idx == gap_at) gap_left = gap_len;
         end else if (in_valid) begin
            waits++;
         end
         @(posedge clk); #1;
         cn++;
      end
      in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
      if (cn >= 1000) check("feed_timeout", cn, 0);
   endtask

   task automatic wait_done(input int len);
      int got = 0;
      int dcyc = -1;
      for (int n = 0; n < 300 && got == 0; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            dcyc = cyc;
         end
      end
      check("done_seen", got, 1);
      check("done_after_pop", dcyc, last_pop + 2);
      check("result_count", nres, len - 8);
      check("scoreboard_empty", exp_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int a8;
      int dn;
      reset = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) sr[i] = '0;
      for (int i = 0; i < 20; i++) s[i] = int'($urandom_range(0, 255));

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {in_ready, cs_x, out_valid, out_data, out_last, busy, done, cfg_err}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // short length rejected
      @(posedge clk); #1;
      start = 1'b1; cfg_len = 16'd8;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_busy", busy, 0);
      @(negedge clk);
      check("cfg_err_one_cycle", cfg_err, 0);
      repeat (3) @(negedge clk);
      check("cfg_err_no_result", out_valid, 0);

      // gap-free frame
      run_frame(20, -1, 0, -100, 0, -1, w, a8);
      check("nogap_waits", w, 0);
      check("first_latency", first_valid, a8 + 2);
      wait_done(20);

      // gap in RUN after 12 accepts: 1 stall + 8 replay cycles
      run_frame(20, 12, 3, -100, 0, -1, w, a8);
      check("run_gap_waits", w, 9);
      wait_done(20);

      // gap in FILL after 5 accepts: 1 stall + 5 replay cycles
      run_frame(20, 5, 3, -100, 0, -1, w, a8);
      check("fill_gap_waits", w, 6);
      wait_done(20);

      // output backpressure for 10 cycles mid-RUN
      run_frame(20, -1, 0, 12, 10, -1, w, a8);
      wait_done(20);

      // reset mid-RUN aborts without done
      run_frame(20, -1, 0, -100, 0, 12, w, a8);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrun_reset_outputs", {in_ready, cs_x, out_valid, out_data, out_last, busy, done, cfg_err}, 0);
      dn = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("no_done_after_reset", dn, 0);

      // minimum frame after reset: one result flagged last
      run_frame(9, -1, 0, -100, 0, -1, w, a8);
      wait_done(9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cs_stream_ctrl.md
Name: cs_stream_ctrl

Overview:
- Sequencing controller in front of the CS sliding-window (WIN=9) selector datapath.
- CS has no stall input, so the controller accepts samples over a valid/ready stream and feeds CS one sample per cycle.
- On any input gap or output backpressure, it rebuilds the CS window by replaying the last WIN-1 samples.
- It frames a run of cfg_len samples, tags which CS Y values are meaningful, and buffers them in a small output FIFO with valid/ready/last.

Parameters:
- DW, 8, sample width (X).
- YW, 10, CS result width (Y).
- WIN, 9, CS window length.
- CS_LAT, 1, posedges from cs_x launch edge to the edge where cs_y reflects that sample's window.
- OFIFO_DEPTH, 4, output FIFO entries (power of 2, ≥ CS_LAT+1).
- LENW, 16, width of cfg_len.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start; honoured only in IDLE.
- cfg_len  in  LENW  input samples in frame; sampled on accepted start.
- in_valid  in  1  sample available.
- in_ready  out  1  controller accepts sample this cycle.
- in_data  in  DW  sample.
- cs_x  out  DW  registered drive to CS X.
- cs_y  in  YW  CS Y.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  YW  FIFO head.
- out_last  out  1  head is the final result of the frame.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  one-cycle pulse: start rejected because cfg_len < WIN.

Behaviour:
- Reset (sync, active-high): state IDLE, FIFO and tag pipe cleared, history count 0. All outputs 0: in_ready, cs_x, out_valid, out_data, out_last, busy, done, cfg_err. Reset mid-frame aborts the frame and emits no done.
- Accept = in_valid & in_ready. An accepted sample is registered into cs_x and pushed into the history ring (WIN-1 entries).
- Credit: in_ready=1 only in FILL/RUN and when FIFO free entries > number of result tags in flight. The FIFO never overflows.
- Tag pipe: length CS_LAT. A tag enters on each accepted sample whose accept index ≥ WIN-1 (0-based). When a tag exits, cs_y is pushed into the FIFO, with last=1 on accept index cfg_len-1.
- Replayed samples never carry tags.
- States:
  - IDLE: start & cfg_len≥WIN → FILL, remain=cfg_len, hist_cnt=0. start & cfg_len<WIN → cfg_err pulse, stay IDLE.
  - FILL: accepts count toward the window. After the (WIN-1)th accept → RUN. No accept in a cycle → STALL.
  - RUN: each accept decrements remain. The accept that brings remain to 0 → DRAIN. No accept → STALL.
  - STALL: in_ready=0, cs_x holds (CS contents treated as corrupt). When in_valid=1 and credit is available → REPLAY, if hist_cnt>0; else back to FILL.
  - REPLAY: in_ready=0. Drives the min(hist_cnt, WIN-1) history samples oldest-first on cs_x, one per cycle, then returns to FILL or RUN (whichever preceded STALL).
  - DRAIN: in_ready=0. Waits until the tag pipe and FIFO are empty (last result popped), then → IDLE with done=1 for one cycle.
- start outside IDLE is ignored.
- Simultaneous FIFO push and pop in one cycle is allowed; occupancy is unchanged.
- Latency: a tagged sample accepted at edge k gives out_valid=1 after edge k+CS_LAT if the FIFO was empty.
- Results count per frame = cfg_len-WIN+1. They are bit-identical to an uninterrupted CS run on the same samples, regardless of gaps or backpressure.

Decomposition:
- Package cs_pkg: DW, YW, WIN localparams; state enum (IDLE, FILL, RUN, STALL, REPLAY, DRAIN); tag struct {valid, last}.
- Sub-module cs_out_fifo: synchronous FIFO of width YW+1, depth OFIFO_DEPTH, with count output used for credit.
- History ring and tag pipe stay inline.

Test Plan:
- cfg_len=20, in_valid and out_ready tied high, CS instance in loop → 12 results matching the golden model; first out_valid exactly CS_LAT edges after the 9th accept; out_last on the 12th; done one cycle after the 12th pop.
- Same frame, in_valid low 3 cycles after accept 12 → STALL then 8 REPLAY cycles with in_ready=0; results identical to the gap-free run.
- Gap after 5 accepts in FILL → replay of exactly 5 samples, then FILL resumes; results identical to the gap-free run.
- out_ready low 10 cycles mid-RUN → in_ready drops once FIFO plus in-flight reaches 4; no lost or duplicated results; replay on resume.
- start with cfg_len=8 → cfg_err pulse, busy stays 0, no results; start while busy ignored.
- reset asserted mid-RUN → all outputs 0 after that edge, no done; a new cfg_len=9 frame yields exactly 1 correct result with out_last=1.
